// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
// Shared types and helpers for the serial link receive path.
//   rx_state_e  : receiver FSM states (IDLE, RECV, PAR)
//   DEF_WORD_W  : default word width
//   cnt_width() : width of a bit counter able to hold 0..width
// ---------------------------------------------------------------------------
package serial_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } rx_state_e;

    localparam int DEF_WORD_W = 4;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// ---------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus bit counter that packs serial bits into a word.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   si          : serial data bit
//   si_valid    : bit qualifier
//   start       : frame align (qualified by si_valid), bit becomes bit 0
//   enable      : receiver is collecting data bits (FSM in RECV)
//   word_done   : combinational, high on the edge that samples bit WIDTH-1
//   word_next   : word as it will be after this edge ({shift, si} view)
//   shift_q     : current shift register contents
// ---------------------------------------------------------------------------
module sipo_shift_core
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = DEF_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             si_valid,
    input  logic             start,
    input  logic             enable,
    output logic             word_done,
    output logic [WIDTH-1:0] word_next,
    output logic [WIDTH-1:0] shift_q
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] base;
    logic             take;

    always_comb begin
        take = si_valid & (start | enable);
        // A start bit always begins from an empty register, dropping any partial word.
        base = start ? '0 : shift_q;
        if (MSB_FIRST) begin
            word_next = {base[WIDTH-2:0], si};
        end else begin
            word_next = {si, base[WIDTH-1:1]};
        end
        // start can never complete a word because WIDTH >= 2.
        word_done = si_valid & ~start & enable & (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            shift_q <= '0;
        end else if (take) begin
            shift_q <= word_next;
            if (start) begin
                cnt <= CW'(1);
            end else if (word_done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sipo_word_rx.sv
// ---------------------------------------------------------------------------
// sipo_word_rx
// Serial-in parallel-out word receiver with one holding register and a
// valid/ready output.
// Optional feature macro: PARITY_CHECK_EN (one even-parity bit per word,
// checked into pout_perr). Default build: no parity bit, pout_perr = 0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   si, si_valid: serial bit and its qualifier
//   start       : frame align, qualified by si_valid
//   pout        : assembled word (holding register)
//   pout_valid  : holding register full
//   pout_ready  : consumer ready
//   pout_perr   : parity error for the word in pout
//   overrun     : sticky, a completed word was dropped
//   ovr_clr     : clears overrun (a simultaneous new overrun wins)
//   state_dbg   : receiver FSM state
// Handshake: a word transfers on every rising edge where pout_valid and
// pout_ready are both 1; pout is stable while pout_valid=1 and pout_ready=0.
// ---------------------------------------------------------------------------
module sipo_word_rx
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = DEF_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             si,
    input  logic             si_valid,
    input  logic             start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             pout_perr,
    output logic             overrun,
    input  logic             ovr_clr,
    output rx_state_e        state_dbg
);

    rx_state_e        state;
    logic             in_recv;
    logic             word_done;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] shift_q;
    logic             complete;
    logic             can_load;
    logic             c_perr;
    logic [WIDTH-1:0] c_word;

    assign in_recv   = (state == RECV);
    assign state_dbg = state;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .si        (si),
        .si_valid  (si_valid),
        .start     (start),
        .enable    (in_recv),
        .word_done (word_done),
        .word_next (word_next),
        .shift_q   (shift_q)
    );

    always_comb begin
        // The holding register can take a word if empty or draining this edge.
        can_load = ~pout_valid | pout_ready;
        // In PAR the data bits already sit in the shift register; si is parity.
        c_word   = (state == PAR) ? shift_q : word_next;
`ifdef PARITY_CHECK_EN
        complete = (state == PAR) & si_valid & ~start;
        c_perr   = ^{shift_q, si};
`else
        complete = word_done;
        c_perr   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pout       <= '0;
            pout_valid <= 1'b0;
            pout_perr  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (si_valid && start) begin
                state <= RECV;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RECV: begin
`ifdef PARITY_CHECK_EN
                        if (word_done) state <= PAR;
`endif
                    end
                    PAR:  if (si_valid) state <= RECV;
                    default: state <= IDLE;
                endcase
            end

            if (complete && can_load) begin
                pout       <= c_word;
                pout_perr  <= c_perr;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            if (complete && !can_load) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_word_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_word_rx
// Self-checking bench for sipo_word_rx (WIDTH=4, MSB_FIRST=1). Expected words
// are pushed as {perr, word} when stimulus is driven and popped when the
// consumer accepts a word.
// ---------------------------------------------------------------------------
module tb_sipo_word_rx;
    import serial_link_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         si;
    logic         si_valid;
    logic         start;
    logic [W-1:0] pout;
    logic         pout_valid;
    logic         pout_ready;
    logic         pout_perr;
    logic         overrun;
    logic         ovr_clr;
    rx_state_e    state_dbg;

    logic [W:0]   exp_q[$];
    logic [W:0]   mon_e;
    int           n_checks = 0;
    int           n_pass   = 0;

    sipo_word_rx #(
        .WIDTH     (W),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .si         (si),
        .si_valid   (si_valid),
        .start      (start),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .pout_perr  (pout_perr),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .state_dbg  (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // scoreboard: compare every accepted word against the queue head
    always @(negedge clk) begin
        if (rst_n && pout_valid && pout_ready) begin
            check("exp_q_level", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("pout", 32'(pout), 32'(mon_e[W-1:0]));
                check("pout_perr", 32'(pout_perr), 32'(mon_e[W]));
            end
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b, input logic st);
        si       = b;
        si_valid = 1'b1;
        start    = st;
        @(posedge clk); #1;
        si_valid = 1'b0;
        start    = 1'b0;
        si       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push(input logic [W-1:0] w, input logic perr);
        exp_q.push_back({perr, w});
    endtask

    function automatic logic exp_perr(input logic [W-1:0] w, input logic p);
`ifdef PARITY_CHECK_EN
        return ^{w, p};
`else
        return p & 1'b0;
`endif
    endfunction

    // MSB first; p is the parity bit sent only in parity builds
    task automatic send_word(input logic [W-1:0] w, input logic st, input logic deliver,
                             input int gap, input logic p);
        if (deliver) push(w, exp_perr(w, p));
        for (int i = W - 1; i >= 0; i--) begin
            drive_bit(w[i], st && (i == W - 1));
            if (gap > 0) idle(gap);
        end
`ifdef PARITY_CHECK_EN
        drive_bit(p, 1'b0);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        si         = 1'b0;
        si_valid   = 1'b0;
        start      = 1'b0;
        pout_ready = 1'b0;
        ovr_clr    = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_pout", 32'(pout), 32'd0);
        check("rst_pout_valid", 32'(pout_valid), 32'd0);
        check("rst_pout_perr", 32'(pout_perr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE ignores bits without start
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        @(negedge clk);
        check("idle_state", 32'(state_dbg), 32'(IDLE));
        check("idle_valid", 32'(pout_valid), 32'd0);

        // 1: single word, consumer ready, one-cycle valid
        pout_ready = 1'b1;
        send_word(4'hB, 1'b1, 1'b1, 0, 1'b1);
        @(negedge clk);
        check("t1_valid", 32'(pout_valid), 32'd1);
        check("t1_pout", 32'(pout), 32'hB);
        @(negedge clk);
        check("t1_valid_drop", 32'(pout_valid), 32'd0);

        // 2: consumer stalled, later words dropped with overrun
        @(posedge clk); #1;
        pout_ready = 1'b0;
        send_word(4'hB, 1'b1, 1'b1, 0, 1'b1);
        send_word(4'h5, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("t2_ovr_5", 32'(overrun), 32'd1);
        check("t2_hold_5", 32'(pout), 32'hB);
        check("t2_valid", 32'(pout_valid), 32'd1);
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        @(negedge clk);
        check("t2_clr1", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        send_word(4'h3, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check("t2_ovr_3", 32'(overrun), 32'd1);
        check("t2_hold_3", 32'(pout), 32'hB);
        // set wins over a clear held across a new overrun
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        send_word(4'h9, 1'b0, 1'b0, 0, 1'b0);
        ovr_clr = 1'b0;
        @(negedge clk);
        check("t2_set_wins", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        @(negedge clk);
        check("t2_clr2", 32'(overrun), 32'd0);
        check("t2_still_b", 32'(pout), 32'hB);
        @(posedge clk); #1;
        pout_ready = 1'b1;
        idle(2);

        // 3: realign mid-word
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        send_word(4'h6, 1'b1, 1'b1, 0, 1'b0);
        @(negedge clk);
        check("t3_pout", 32'(pout), 32'h6);
        check("t3_overrun", 32'(overrun), 32'd0);
        idle(2);

        // 4: si_valid toggling, latency from the last sampled bit
        push(4'h7, exp_perr(4'h7, 1'b1));
        drive_bit(1'b0, 1'b1); idle(1);
        drive_bit(1'b1, 1'b0); idle(1);
        drive_bit(1'b1, 1'b0); idle(1);
        @(negedge clk);
        check("t4_not_yet", 32'(pout_valid), 32'd0);
        @(posedge clk); #1;
        drive_bit(1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        idle(1);
        @(negedge clk);
        check("t4_wait_par", 32'(pout_valid), 32'd0);
        @(posedge clk); #1;
        drive_bit(1'b1, 1'b0);
`endif
        @(negedge clk);
        check("t4_valid", 32'(pout_valid), 32'd1);
        check("t4_pout", 32'(pout), 32'h7);
        idle(2);

        // 6: parity bit stream 1010 0 1010 1
`ifdef PARITY_CHECK_EN
        push(4'hA, 1'b0);
        push(4'hA, 1'b1);
`else
        push(4'hA, 1'b0);
        push(4'h5, 1'b0);
`endif
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        idle(3);

        // 5: asynchronous reset mid-word
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_pout", 32'(pout), 32'd0);
        check("t5_valid", 32'(pout_valid), 32'd0);
        check("t5_perr", 32'(pout_perr), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(4'hC, 1'b1, 1'b1, 0, 1'b0);
        @(negedge clk);
        check("t5_pout_c", 32'(pout), 32'hC);
        idle(2);

        // random words with random gaps
        for (int i = 0; i < 8; i++) begin
            send_word(4'($urandom_range(0, 15)), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                      1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // bounded drain
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
